// File: rtl/cop_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// cop_sequencer_pkg
// Shared definitions for the coprocessor sequencer:
//   - cop_state_e : sequencer FSM state encoding
//   - SEL_*       : coprocessor selector constants (11-bit cop_sel values)
//   - rd_sel()    : widens a 4-bit result selector to a full cop_sel value
// -----------------------------------------------------------------------------
package cop_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TRIG = 3'd1,
        ST_POLL = 3'd2,
        ST_WAIT = 3'd3,
        ST_RDA  = 3'd4,
        ST_RDB  = 3'd5,
        ST_LAST = 3'd6,
        ST_RSP  = 3'd7
    } cop_state_e;

    localparam logic [10:0] SEL_BUSY     = 11'd0;
    localparam logic [10:0] SEL_OPTIONS  = 11'd1;
    localparam logic [10:0] SEL_MULT_HI  = 11'd2;
    localparam logic [10:0] SEL_MULT_LO  = 11'd3;
    localparam logic [10:0] SEL_QUOT     = 11'd4;
    localparam logic [10:0] SEL_REM      = 11'd5;
    localparam logic [10:0] SEL_SHIFT_HI = 11'd6;
    localparam logic [10:0] SEL_SHIFT_LO = 11'd7;
    localparam logic [10:0] SEL_COLOR    = 11'd8;

    // Result selectors only address the low 16 coprocessor registers.
    function automatic logic [10:0] rd_sel(input logic [3:0] rsel);
        return {7'b000_0000, rsel};
    endfunction

endpackage

// File: rtl/cop_sequencer_if.sv
// -----------------------------------------------------------------------------
// cop_sequencer_if
// Bundles the three sequencer-facing buses:
//   req_* : request channel (valid/ready, opcode, operands, result selection)
//   cop_* : coprocessor drive (sel, go, a/b/c) and its registered result y
//   rsp_* : response channel (valid/ready, hi/lo words, timeout flag)
// Modports:
//   slave  : the sequencer itself
//   master : the requester plus the coprocessor attached to the sequencer
// -----------------------------------------------------------------------------
interface cop_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [10:0]      req_sel;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [WIDTH-1:0] req_c;
    logic [3:0]       req_rsel;
    logic             req_pair;

    logic [10:0]      cop_sel;
    logic             cop_go;
    logic [WIDTH-1:0] cop_a;
    logic [WIDTH-1:0] cop_b;
    logic [WIDTH-1:0] cop_c;
    logic [WIDTH-1:0] cop_y;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_hi;
    logic [WIDTH-1:0] rsp_lo;
    logic             rsp_timeout;

    modport slave (
        input  req_valid, req_sel, req_a, req_b, req_c, req_rsel, req_pair,
        output req_ready,
        output cop_sel, cop_go, cop_a, cop_b, cop_c,
        input  cop_y,
        output rsp_valid, rsp_hi, rsp_lo, rsp_timeout,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_sel, req_a, req_b, req_c, req_rsel, req_pair,
        input  req_ready,
        input  cop_sel, cop_go, cop_a, cop_b, cop_c,
        output cop_y,
        input  rsp_valid, rsp_hi, rsp_lo, rsp_timeout,
        output rsp_ready
    );

endinterface

// File: rtl/cop_sequencer_wdog.sv
// -----------------------------------------------------------------------------
// cop_wdog
// Busy-poll watchdog: counts enabled cycles since the last clear and flags
// when the current enabled cycle is the TMO_CYCLES-th one.
// Ports:
//   clk, arstn : clock, asynchronous active-low reset
//   clear_i    : restart the count (new operation triggered)
//   enable_i   : one busy poll cycle observed
//   expired_o  : TMO_CYCLES-1 busy cycles already counted
// -----------------------------------------------------------------------------
module cop_wdog #(
    parameter int TMO_CYCLES = 64
) (
    input  logic clk,
    input  logic arstn,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int CW = $clog2(TMO_CYCLES + 1);

    logic [CW-1:0] count_q;

    // Expired while the limit-th busy cycle is being observed.
    assign expired_o = (count_q == CW'(TMO_CYCLES - 1));

    // Busy-cycle counter; saturates at the expiry value.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i && !expired_o) begin
            count_q <= count_q + CW'(1);
        end else begin
            count_q <= count_q;
        end
    end

endmodule

// File: rtl/cop_sequencer.sv
// -----------------------------------------------------------------------------
// cop_sequencer
// Runs one coprocessor operation per accepted request: trigger, busy poll,
// wait for not-busy, read one or two result registers, present a response.
// Ports:
//   clk, arstn : clock, asynchronous active-low reset
//   bus        : cop_sequencer_if.slave (request, coprocessor and response)
// Parameters:
//   WIDTH      : datapath width (must match the interface WIDTH)
//   TMO_CYCLES : busy-poll watchdog limit
// Optional feature: define COPSEQ_TIMEOUT_EN to enable the busy watchdog;
// otherwise WAIT waits indefinitely and rsp_timeout is tied low.
// -----------------------------------------------------------------------------
module cop_sequencer
    import cop_sequencer_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int TMO_CYCLES = 64
) (
    input  logic          clk,
    input  logic          arstn,
    cop_sequencer_if.slave bus
);
    cop_state_e       state_q;
    logic [WIDTH-1:0] a_q, b_q, c_q;
    logic [3:0]       rsel_q;
    logic             pair_q;
    logic [10:0]      cop_sel_q;
    logic             cop_go_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_hi_q, rsp_lo_q;
    logic             busy_s;

    if (TMO_CYCLES < 1) begin : g_bad_tmo
        $error("cop_sequencer: TMO_CYCLES must be at least 1");
    end

    assign busy_s = bus.cop_y[0];

    // Ready is held low while reset is asserted so nothing looks acceptable.
    assign bus.req_ready = (state_q == ST_IDLE) && arstn;
    assign bus.cop_sel   = cop_sel_q;
    assign bus.cop_go    = cop_go_q;
    assign bus.cop_a     = a_q;
    assign bus.cop_b     = b_q;
    assign bus.cop_c     = c_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_hi    = rsp_hi_q;
    assign bus.rsp_lo    = rsp_lo_q;

`ifdef COPSEQ_TIMEOUT_EN
    logic rsp_timeout_q;
    logic wd_expired_s;

    assign bus.rsp_timeout = rsp_timeout_q;

    cop_wdog #(.TMO_CYCLES(TMO_CYCLES)) u_wdog (
        .clk       (clk),
        .arstn     (arstn),
        .clear_i   (state_q == ST_TRIG),
        .enable_i  ((state_q == ST_WAIT) && busy_s),
        .expired_o (wd_expired_s)
    );
`else
    assign bus.rsp_timeout = 1'b0;
`endif

    // Sequencer FSM; cop_go/cop_sel are set one edge ahead so they are valid
    // for the whole cycle of the state they belong to.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            rsel_q      <= 4'd0;
            pair_q      <= 1'b0;
            cop_sel_q   <= SEL_BUSY;
            cop_go_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_hi_q    <= '0;
            rsp_lo_q    <= '0;
`ifdef COPSEQ_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        a_q       <= bus.req_a;
                        b_q       <= bus.req_b;
                        c_q       <= bus.req_c;
                        rsel_q    <= bus.req_rsel;
                        pair_q    <= bus.req_pair;
                        cop_go_q  <= 1'b1;
                        cop_sel_q <= bus.req_sel;
                        state_q   <= ST_TRIG;
`ifdef COPSEQ_TIMEOUT_EN
                        rsp_timeout_q <= 1'b0;
`endif
                    end else begin
                        cop_go_q  <= 1'b0;
                        cop_sel_q <= SEL_BUSY;
                    end
                end
                ST_TRIG: begin
                    cop_go_q  <= 1'b1;
                    cop_sel_q <= SEL_BUSY;
                    state_q   <= ST_POLL;
                end
                ST_POLL: begin
                    cop_go_q  <= 1'b0;
                    cop_sel_q <= SEL_BUSY;
                    state_q   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!busy_s) begin
                        cop_go_q  <= 1'b1;
                        cop_sel_q <= rd_sel(rsel_q);
                        state_q   <= ST_RDA;
`ifdef COPSEQ_TIMEOUT_EN
                    end else if (wd_expired_s) begin
                        rsp_hi_q      <= '0;
                        rsp_lo_q      <= '0;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= ST_RSP;
`endif
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_RDA: begin
                    // The second read is issued here so its result lands for LAST.
                    if (pair_q) begin
                        cop_go_q  <= 1'b1;
                        cop_sel_q <= rd_sel(rsel_q + 4'd1);
                    end else begin
                        cop_go_q  <= 1'b0;
                        cop_sel_q <= SEL_BUSY;
                    end
                    state_q <= ST_RDB;
                end
                ST_RDB: begin
                    cop_go_q  <= 1'b0;
                    cop_sel_q <= SEL_BUSY;
                    if (pair_q) begin
                        rsp_hi_q <= bus.cop_y;
                        state_q  <= ST_LAST;
                    end else begin
                        rsp_hi_q    <= '0;
                        rsp_lo_q    <= bus.cop_y;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RSP;
                    end
                end
                ST_LAST: begin
                    rsp_lo_q    <= bus.cop_y;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RSP;
                end
                ST_RSP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        state_q <= ST_RSP;
                    end
                end
                default: begin
                    cop_go_q    <= 1'b0;
                    cop_sel_q   <= SEL_BUSY;
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cop_sequencer.md
COP_SEQUENCER -- requirements
Module: cop_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width matching the coprocessor.
REQ-002 SHALL have parameter TMO_CYCLES, default 64, busy-poll watchdog limit (used only with COPSEQ_TIMEOUT_EN).
REQ-003 SHALL have ports (reset arstn, asynchronous, active-low; clock clk):
- clk  in  1  clock
- arstn  in  1  async reset, active-low
- req_valid  in  1  request present
- req_ready  out  1  sequencer idle, request accepted when both high
- req_sel  in  11  coprocessor opcode/trigger select
- req_a, req_b, req_c  in  WIDTH  tos, nos, w operands
- req_rsel  in  4  first result selector
- req_pair  in  1  1 = also read result selector req_rsel+1
- cop_sel  out  11  to coprocessor sel
- cop_go  out  1  to coprocessor go
- cop_a, cop_b, cop_c  out  WIDTH  to coprocessor a, b, c
- cop_y  in  WIDTH  coprocessor registered result
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed
- rsp_hi, rsp_lo  out  WIDTH  result words
- rsp_timeout  out  1  watchdog expiry flag

Function
REQ-004 SHALL use states IDLE, TRIG, POLL, WAIT, RDA, RDB, LAST, RSP; req_ready = (state==IDLE).
REQ-005 IDLE: on req_valid&req_ready, SHALL register req_sel, req_a/b/c, req_rsel, req_pair; next TRIG.
REQ-006 cop_a/b/c SHALL drive the registered operands, stable from TRIG until return to IDLE.
REQ-007 TRIG: cop_go=1, cop_sel=registered req_sel, one cycle; next POLL; watchdog count cleared.
REQ-008 POLL: cop_go=1, cop_sel=0 (busy selector), one cycle; next WAIT.
REQ-009 WAIT: cop_go=0; cop_y[0]=0 -> RDA; cop_y[0]=1 -> stay and increment watchdog.
REQ-010 RDA: cop_go=1, cop_sel={7'b0,req_rsel}; next RDB.
REQ-011 RDB: pair -> rsp_hi<=cop_y, cop_go=1, cop_sel={7'b0,req_rsel+1 (mod 16)}, next LAST; single -> rsp_lo<=cop_y, rsp_hi<=0, cop_go=0, next RSP.
REQ-012 LAST: rsp_lo<=cop_y, cop_go=0; next RSP.
REQ-013 RSP: rsp_valid=1, rsp_hi/lo/timeout stable until rsp_ready=1; then IDLE, rsp_valid=0 next cycle.
REQ-014 cop_go SHALL be 0 and cop_sel 0 in IDLE, WAIT, LAST, RSP.
REQ-015 Latency (acceptance edge to rsp_valid high), busy-free op: 6 cycles pair, 5 single; plus one cycle per WAIT cycle with cop_y[0]=1.
REQ-016 req_valid while not IDLE SHALL be ignored; no request queuing.

Reset
REQ-017 arstn low SHALL force state IDLE, cop_go=0, cop_sel=0, cop_a/b/c=0, rsp_valid=0, rsp_hi/lo=0, rsp_timeout=0, watchdog=0, at any time including mid-operation; no request accepted while arstn low.
REQ-018 After reset release, first accepted request SHALL be processed normally; no residual state.

Configuration
REQ-019 With COPSEQ_TIMEOUT_EN defined: watchdog reaching TMO_CYCLES consecutive busy WAIT cycles SHALL go to RSP with rsp_timeout=1, rsp_hi=rsp_lo=0, no result reads issued.
REQ-020 Without COPSEQ_TIMEOUT_EN: WAIT SHALL wait indefinitely, rsp_timeout tied 0, no watchdog flops.

Structure
REQ-021 Shared package/include SHALL hold state encoding and coprocessor selector constants (busy=0, options=1, mult hi/lo=2/3, quot/rem=4/5, shift hi/lo=6/7, color=8).
REQ-022 Watchdog counter SHALL be sub-module cop_wdog (clear, enable, expired), instantiated only under COPSEQ_TIMEOUT_EN.

Verification
REQ-023 Stub busy never set, req_rsel=2, pair=1, stub y=0x1234/0x5678 -> rsp_hi=0x1234, rsp_lo=0x5678, rsp_valid 6 cycles after acceptance; cop_go pattern 1,1,0,1,1,0.
REQ-024 Stub busy 10 cycles -> rsp_valid 16 cycles after acceptance; cop_a/b/c constant throughout.
REQ-025 req_rsel=1, pair=0, stub y=0x00A5 -> rsp_hi=0, rsp_lo=0x00A5, rsp_valid 5 cycles after acceptance.
REQ-026 rsp_ready held low 3 cycles in RSP -> outputs stable, req_ready=0, new req_valid ignored until handshake.
REQ-027 Busy stuck, TMO_CYCLES=64, COPSEQ_TIMEOUT_EN -> rsp_timeout=1, rsp_hi=rsp_lo=0 after 64 WAIT cycles; undefined macro -> no rsp_valid after 1000 cycles.
REQ-028 arstn pulsed low during WAIT -> all outputs 0 immediately, req_ready=1 after release, next request matches REQ-023.
